pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the team's combinational 4-bit ripple adder.
- Splits a WIDTH-bit add/subtract into SEG-bit ripple segments, one segment per pipeline stage, so the carry passes between stages through registers.
- Uses a valid/ready handshake on input and output, and supports full backpressure.
- Instantiated wherever wide add/sub must close timing at high clock rates.

---
 rtl/pipelined_addsub.sv | 98 +++++++++
 tb/tb_pipelined_addsub.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract split into SEG-bit ripple segments, one segment per
// pipeline stage, with a valid/ready handshake and a global stall enable.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_cfg_err
        $error("pipelined_addsub: WIDTH must be a positive multiple of SEG");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;

    // Whole pipe moves as one; a held output freezes every stage behind it.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int BW = WIDTH - k * SEG;

        // acc holds finished sum segments below k and raw A bits above.
        logic [WIDTH-1:0] acc_i, acc_nx, acc_q;
        logic [BW-1:0]    b_i;
        logic             c_i, v_i;
        logic             c_q, v_q;
        logic [SEG:0]     seg;

        if (k == 0) begin : g_src
            assign acc_i = a;
            assign b_i   = b_eff;
            assign c_i   = cin ^ sub;
            assign v_i   = in_valid;
        end else begin : g_src
            assign acc_i = g_stage[k-1].acc_q;
            assign b_i   = g_stage[k-1].g_bh.bh_q;
            assign c_i   = g_stage[k-1].c_q;
            assign v_i   = g_stage[k-1].v_q;
        end

        assign seg = {1'b0, acc_i[k*SEG +: SEG]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};

        always_comb begin
            acc_nx               = acc_i;
            acc_nx[k*SEG +: SEG] = seg[SEG-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                acc_q <= '0;
            end else if (en) begin
                v_q   <= v_i;
                c_q   <= seg[SEG];
                acc_q <= acc_nx;
            end
        end

        if (k < STAGES - 1) begin : g_bh
            // Only the not-yet-consumed upper B' segments travel on.
            logic [BW-SEG-1:0] bh_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  bh_q <= '0;
                else if (en) bh_q <= b_i[BW-1:SEG];
            end
        end else begin : g_last
            // Carry into the MSB is recovered as a ^ b' ^ sum at the top bit.
            logic ovf_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  ovf_q <= 1'b0;
                else if (en) ovf_q <= seg[SEG] ^ acc_i[WIDTH-1] ^ b_i[SEG-1] ^ seg[SEG-1];
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].acc_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=16, SEG=4): accepted beats push
// model results, a monitor pops and compares on each retiring output beat.
module tb_pipelined_addsub;
    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    pipelined_addsub #(.WIDTH(W), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t   q[$];
    int     checks = 0, failures = 0, cyc = 0;
    bit     no_stall = 1'b1;
    bit     held = 1'b0;
    logic [W-1:0] h_sum;
    logic   h_cout, h_ovf;
    exp_t   acc_e, mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: integer arithmetic, no bit-level adder structure.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
        exp_t e;
        int ua = int'(x), ub = int'(y), sa = int'($signed(x)), sy = int'($signed(y));
        int c = ci ? 1 : 0;
        int r, rs;
        if (!sb) begin
            r = ua + ub + c;  rs = sa + sy + c;  e.co = (r > 65535);
        end else begin
            r = ua - ub - c;  rs = sa - sy - c;  e.co = (r >= 0);
        end
        e.s   = r[W-1:0];
        e.ov  = (rs > 32767) || (rs < -32768);
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            acc_e     = model(a, b, cin, sub);
            acc_e.cyc = cyc;
            acc_e.lat = no_stall;
            q.push_back(acc_e);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_beat actual sum=%0h expected no beat", sum);
                end else begin
                    mon_e = q.pop_front();
                    chk("sum", 32'(sum), 32'(mon_e.s));
                    chk("cout", 32'(cout), 32'(mon_e.co));
                    chk("ovf", 32'(ovf), 32'(mon_e.ov));
                    if (mon_e.lat) chk("latency", 32'(cyc - mon_e.cyc), LAT);
                end
            end
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(sum), 32'(h_sum));
                chk("hold_flags", {30'd0, cout, ovf}, {30'd0, h_cout, h_ovf});
            end
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            held   <= out_valid && !out_ready;
            h_sum  <= sum;
            h_cout <= cout;
            h_ovf  <= ovf;
        end
    end

    task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
        int n = 0;
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout actual in_ready=0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            n++;
            @(posedge clk);
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    bit done;

    initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_flags", {30'd0, cout, ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, back to back, no stalls.
        no_stall = 1'b1;
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0010, 16'h0003, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
        drain();

        // Same stream with out_ready low for cycles 5..7.
        no_stall = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Alternating beats and bubbles.
        no_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
            idle();
        end
        drain();

        // Random traffic with random backpressure.
        no_stall = 1'b0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset while a result is held at the output and the pipe is full.
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b1, 1'b0);
        send(16'hF00F, 16'h0FF0, 1'b0, 1'b0);
        send(16'h8001, 16'h0002, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        q.delete();
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_sum", 32'(sum), 32'd0);
        chk("midreset_flags", {30'd0, cout, ovf}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        no_stall = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("no_stale_beat", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
